onewire_slave: RTL and testbench
================================

ONEWIRE_SLAVE -- requirements
Module: onewire_slave

Interface
REQ-001 The block SHALL expose parameter CLK_PER_US, default 50, giving clock cycles per microsecond.
REQ-002 The block SHALL expose parameter ROM_ID, 64 bits, default 64'hA2000000_01234528, holding the device ROM code, sent LSB first.
REQ-003 The block SHALL expose parameter CONV_US, default 750000, giving temperature conversion time in microseconds.
REQ-004 Ports SHALL be: clk  in  1  system clock; rst_n  in  1  reset, synchronous, active-low; dq_in  in  1  1-Wire bus level; dq_pull  out  1  1 = drive bus low; temp_in  in  16  temperature sample; cmd_byte  out  8  last received byte; cmd_valid  out  1  one-cycle strobe per received byte; conv_busy  out  1  conversion in progress.

Function
REQ-005 dq_in SHALL pass through a 2-flop synchronizer; all timing uses the synchronized level.
REQ-006 A bus-low interval of at least 480 us SHALL be a reset pulse, aborting any state except conversion timing.
REQ-007 After the reset pulse rises, the block SHALL wait 30 us, then assert dq_pull for 120 us (presence), then enter ROM_CMD.
REQ-008 Each bus falling edge outside PRESENCE SHALL start a time slot; a written bit SHALL be the synchronized level 30 us after the falling edge.
REQ-009 In a read slot sending 0, dq_pull SHALL assert on the cycle after the detected falling edge and hold 30 us; sending 1, dq_pull SHALL stay 0.
REQ-010 Bytes SHALL be received and sent LSB first; cmd_byte/cmd_valid SHALL update on the 8th received bit of every byte.
REQ-011 FSM states SHALL be IDLE, PRES_WAIT, PRESENCE, ROM_CMD, MATCH_ROM, READ_ROM, FUNC_CMD, READ_SP, CONV_POLL.
REQ-012 ROM_CMD: 8'h55 -> MATCH_ROM; 8'hCC -> FUNC_CMD; 8'h33 -> READ_ROM; any other -> IDLE.
REQ-013 MATCH_ROM SHALL compare 64 received bits with ROM_ID; all equal -> FUNC_CMD; any mismatch -> IDLE after the 64th bit.
REQ-014 READ_ROM SHALL send the 64 ROM_ID bits, then go to FUNC_CMD.
REQ-015 FUNC_CMD: 8'h44 -> start conversion and enter CONV_POLL; 8'hBE -> READ_SP; other -> IDLE.
REQ-016 Conversion SHALL set conv_busy for CONV_US*CLK_PER_US cycles, then latch temp_in into the temperature register and clear conv_busy.
REQ-017 CONV_POLL read slots SHALL return 0 while conv_busy=1 and 1 afterwards; the state persists until reset pulse.
REQ-018 The 9-byte scratchpad SHALL be temp LSB, temp MSB, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, byte8.
REQ-019 READ_SP SHALL send scratchpad bytes 0..8 in order, then send 1s; a reset pulse ends the read at any bit.
REQ-020 A reset pulse during conversion SHALL NOT stop conversion; 8'h44 during conv_busy=1 SHALL restart the counter.
REQ-021 IDLE SHALL ignore all slots, keeping dq_pull 0, until a reset pulse.
REQ-022 A falling edge inside an active 30 us slot window SHALL be ignored.

Reset
REQ-023 On rst_n=0 at a clk edge: state IDLE, dq_pull 0, cmd_byte 8'h00, cmd_valid 0, conv_busy 0, temperature register 16'h0550, counters 0.
REQ-024 rst_n deassertion SHALL take effect on the next clk edge; no bus activity before a full reset pulse.

Configuration
REQ-025 Macro ONEWIRE_SLAVE_CRC_EN defined: byte8 SHALL be Dallas CRC-8 (x^8+x^5+x^4+1, init 0) over bytes 0..7.
REQ-026 Macro ONEWIRE_SLAVE_CRC_EN undefined: byte8 SHALL be 8'h00 and no CRC logic is built.

Verification
REQ-027 rst_n low 2 cycles -> dq_pull 0, conv_busy 0, temperature register 16'h0550.
REQ-028 Bus low 500 us then release -> dq_pull high from 30 us to 150 us after release.
REQ-029 Reset, 8'h33, 64 read slots -> recovered bits equal ROM_ID, LSB first.
REQ-030 Reset, 8'h55, ROM_ID with bit 0 flipped, 8'hBE, read slots -> all read 1 (IDLE).
REQ-031 CONV_US=10; reset, 8'hCC, 8'h44, temp_in 16'h0191 -> slots read 0 for 10 us, then 1; reset, 8'hCC, 8'hBE -> bytes 91, 01, 4B, 46, 7F, FF, 0C, 10, CRC (CRC_EN) or 00.
REQ-032 Bus low 500 us during READ_SP byte 3 -> presence pulse generated, state ROM_CMD.

Source files
------------

// File: rtl/onewire_slave.sv
// 1-Wire temperature-sensor slave: reset/presence, ROM commands, conversion and scratchpad read.
// Define ONEWIRE_SLAVE_CRC_EN to append a Dallas CRC-8 as scratchpad byte 8 (otherwise 8'h00).
module onewire_slave #(
    parameter int          CLK_PER_US = 50,
    parameter logic [63:0] ROM_ID     = 64'hA2000000_01234528,
    parameter int          CONV_US    = 750000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dq_in,
    output logic        dq_pull,
    input  logic [15:0] temp_in,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        conv_busy
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] PRES_WAIT = 4'd1;
    localparam logic [3:0] PRESENCE  = 4'd2;
    localparam logic [3:0] ROM_CMD   = 4'd3;
    localparam logic [3:0] MATCH_ROM = 4'd4;
    localparam logic [3:0] READ_ROM  = 4'd5;
    localparam logic [3:0] FUNC_CMD  = 4'd6;
    localparam logic [3:0] READ_SP   = 4'd7;
    localparam logic [3:0] CONV_POLL = 4'd8;

    localparam logic [31:0] RST_CYC  = 32'(480 * CLK_PER_US);
    localparam logic [31:0] PW_CYC   = 32'(30 * CLK_PER_US);
    localparam logic [31:0] PR_CYC   = 32'(120 * CLK_PER_US);
    localparam logic [31:0] SLOT_CYC = 32'(30 * CLK_PER_US);
    localparam logic [31:0] CONV_CYC = 32'(CONV_US * CLK_PER_US);

    logic [3:0]  state;
    logic        dq_s1, dq_s2, dq_prev;
    logic [31:0] tmr, low_cnt, conv_cnt;
    logic        slot_active;
    logic [6:0]  bit_idx;
    logic [7:0]  rx_byte;
    logic        mismatch;
    logic [15:0] temp_reg;

    logic        fall, rise, tx_bit, is_read, match_fail;
    logic [7:0]  rx_next, byte8;
    logic [63:0] sp_lo;
    logic [71:0] sp;

    assign fall       = dq_prev & ~dq_s2;
    assign rise       = ~dq_prev & dq_s2;
    assign rx_next    = {dq_s2, rx_byte[7:1]};
    assign match_fail = mismatch | (dq_s2 != ROM_ID[bit_idx[5:0]]);
    assign is_read    = (state == READ_ROM) || (state == READ_SP) || (state == CONV_POLL);
    assign sp_lo      = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, temp_reg};
    assign sp         = {byte8, sp_lo};

`ifdef ONEWIRE_SLAVE_CRC_EN
    // Dallas CRC-8 (x^8+x^5+x^4+1, reflected 8'h8C), fed LSB first.
    function automatic logic [7:0] crc8(input logic [63:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 64; i++)
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? 8'h8C : 8'h00);
        return c;
    endfunction
    assign byte8 = crc8(sp_lo);
`else
    assign byte8 = 8'h00;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tx_bit = 1'b1;
        case (state)
            READ_ROM:  tx_bit = ROM_ID[bit_idx[5:0]];
            READ_SP:   if (bit_idx < 7'd72) tx_bit = sp[bit_idx];
            CONV_POLL: tx_bit = ~conv_busy;
            default:   tx_bit = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; sync flops reset to the idle-high bus level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;  dq_pull <= 1'b0;  cmd_byte <= 8'h00;  cmd_valid <= 1'b0;
            conv_busy <= 1'b0;  temp_reg <= 16'h0550;
            dq_s1 <= 1'b1;  dq_s2 <= 1'b1;  dq_prev <= 1'b1;
            tmr <= '0;  low_cnt <= '0;  conv_cnt <= '0;
            slot_active <= 1'b0;  bit_idx <= '0;  rx_byte <= '0;  mismatch <= 1'b0;
        end else begin
            dq_s1     <= dq_in;
            dq_s2     <= dq_s1;
            dq_prev   <= dq_s2;
            cmd_valid <= 1'b0;

            if (dq_s2)                  low_cnt <= '0;
            else if (low_cnt != RST_CYC) low_cnt <= low_cnt + 32'd1;

            // Conversion timing runs independently of the bus protocol; a new 0x44 below overrides it.
            if (conv_busy) begin
                if (conv_cnt == CONV_CYC - 32'd1) begin
                    conv_busy <= 1'b0;
                    conv_cnt  <= '0;
                    temp_reg  <= temp_in;
                end else begin
                    conv_cnt <= conv_cnt + 32'd1;
                end
            end

            if (rise && low_cnt >= RST_CYC) begin
                state       <= PRES_WAIT;
                tmr         <= '0;
                dq_pull     <= 1'b0;
                slot_active <= 1'b0;
                bit_idx     <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    PRES_WAIT:
                        if (tmr == PW_CYC - 32'd1) begin
                            state <= PRESENCE;  tmr <= '0;  dq_pull <= 1'b1;
                        end else tmr <= tmr + 32'd1;
                    PRESENCE:
                        if (tmr == PR_CYC - 32'd1) begin
                            state <= ROM_CMD;  tmr <= '0;  dq_pull <= 1'b0;
                            bit_idx <= '0;  mismatch <= 1'b0;
                        end else tmr <= tmr + 32'd1;
                    default:
                        if (slot_active) begin
                            if (tmr == SLOT_CYC - 32'd1) begin
                                slot_active <= 1'b0;
                                dq_pull     <= 1'b0;
                                tmr         <= '0;
                                bit_idx     <= bit_idx + 7'd1;
                                if (!is_read) begin
                                    rx_byte <= rx_next;
                                    if (bit_idx[2:0] == 3'd7) begin
                                        cmd_byte  <= rx_next;
                                        cmd_valid <= 1'b1;
                                    end
                                end
                                case (state)
                                    ROM_CMD:
                                        if (bit_idx[2:0] == 3'd7) begin
                                            bit_idx  <= '0;
                                            mismatch <= 1'b0;
                                            case (rx_next)
                                                8'h55:   state <= MATCH_ROM;
                                                8'hCC:   state <= FUNC_CMD;
                                                8'h33:   state <= READ_ROM;
                                                default: state <= IDLE;
                                            endcase
                                        end
                                    MATCH_ROM: begin
                                        mismatch <= match_fail;
                                        if (bit_idx == 7'd63) begin
                                            bit_idx <= '0;
                                            state   <= match_fail ? IDLE : FUNC_CMD;
                                        end
                                    end
                                    READ_ROM:
                                        if (bit_idx == 7'd63) begin
                                            bit_idx <= '0;
                                            state   <= FUNC_CMD;
                                        end
                                    FUNC_CMD:
                                        if (bit_idx[2:0] == 3'd7) begin
                                            bit_idx <= '0;
                                            case (rx_next)
                                                8'h44: begin
                                                    state     <= CONV_POLL;
                                                    conv_busy <= 1'b1;
                                                    conv_cnt  <= '0;
                                                end
                                                8'hBE:   state <= READ_SP;
                                                default: state <= IDLE;
                                            endcase
                                        end
                                    READ_SP:
                                        if (bit_idx == 7'd72) bit_idx <= bit_idx;
                                    default: bit_idx <= bit_idx;
                                endcase
                            end else begin
                                tmr <= tmr + 32'd1;
                            end
                        end else if (fall) begin
                            slot_active <= 1'b1;
                            tmr         <= '0;
                            if (is_read) dq_pull <= ~tx_bit;
                        end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onewire_slave.sv
// Scoreboard bench for onewire_slave: a bus master drives slots; monitors pop expected bytes/bits.
module tb_onewire_slave;

    localparam int          CPU     = 3;
    localparam int          CONV    = 10;
    localparam logic [63:0] ROM     = 64'hA2000000_01234528;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dq_in;
    logic        dq_pull;
    logic [15:0] temp_in = 16'h0191;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic        conv_busy;
    logic        master_low = 1'b0;

    onewire_slave #(.CLK_PER_US(CPU), .ROM_ID(ROM), .CONV_US(CONV)) dut (
        .clk(clk), .rst_n(rst_n), .dq_in(dq_in), .dq_pull(dq_pull),
        .temp_in(temp_in), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .conv_busy(conv_busy)
    );

    // Open-drain bus: low if either side pulls.
    assign dq_in = ~(master_low | (dq_pull === 1'b1));
    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_cmd[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rd_data;
    event       rd_ev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [7:0] ref_crc(input logic [63:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            fb = c[0] ^ d[i];
            c  = {fb, c[7:1]};
            c[3] = c[3] ^ fb;
            c[2] = c[2] ^ fb;
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (rst_n && cmd_valid === 1'b1) begin
            if (exp_cmd.size() == 0) begin
                n_total++;
                $display("FAIL cmd_unexpected: got %0h, want none", cmd_byte);
            end else check("cmd_byte", cmd_byte, exp_cmd.pop_front());
        end
    end

    always @(rd_ev) begin
        if (exp_rd.size() == 0) begin
            n_total++;
            $display("FAIL read_unexpected: got %0h, want none", rd_data);
        end else check("read_data", rd_data, exp_rd.pop_front());
    end

    task automatic wait_us(input int us);
        repeat (us * CPU) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        master_low = 1'b1;
        wait_us(b ? 2 : 33);
        master_low = 1'b0;
        wait_us(b ? 33 : 2);
    endtask

    task automatic write_byte(input logic [7:0] v, input logic expect_cmd);
        if (expect_cmd) exp_cmd.push_back(v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    task automatic read_bit(output logic b);
        master_low = 1'b1;
        wait_us(2);
        master_low = 1'b0;
        wait_us(13);
        b = dq_in;
        wait_us(20);
    endtask

    task automatic read_byte(input logic [7:0] exp);
        logic [7:0] v;
        exp_rd.push_back(exp);
        for (int i = 0; i < 8; i++) read_bit(v[i]);
        rd_data = v;
        -> rd_ev;
    endtask

    task automatic read_one(input logic exp);
        logic b;
        exp_rd.push_back({7'b0, exp});
        read_bit(b);
        rd_data = {7'b0, b};
        -> rd_ev;
    endtask

    task automatic bus_reset();
        master_low = 1'b1;
        wait_us(500);
        master_low = 1'b0;
        wait_us(25);  check("pres_before_30us", dq_pull, 1'b0);
        wait_us(10);  check("pres_at_35us", dq_pull, 1'b1);
        wait_us(110); check("pres_at_145us", dq_pull, 1'b1);
        wait_us(10);  check("pres_after_150us", dq_pull, 1'b0);
        wait_us(5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] bad_rom;
        logic [7:0]  sp_exp[9];
        logic [63:0] sp_lo;

        repeat (2) @(negedge clk);
        check("rst_dq_pull", dq_pull, 1'b0);
        check("rst_conv_busy", conv_busy, 1'b0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_byte", cmd_byte, 8'h00);
        rst_n = 1'b1;
        wait_us(5);

        // Before any reset pulse the slave ignores slots.
        read_one(1'b1);
        write_byte(8'hCC, 1'b0);

        // Reset-value temperature visible in scratchpad.
        bus_reset();
        write_byte(8'hCC, 1'b1);
        write_byte(8'hBE, 1'b1);
        read_byte(8'h50);
        read_byte(8'h05);

        // READ_ROM then function command.
        bus_reset();
        write_byte(8'h33, 1'b1);
        for (int i = 0; i < 8; i++) read_byte(ROM[8*i +: 8]);
        write_byte(8'hBE, 1'b1);
        read_byte(8'h50);

        // MATCH_ROM with bit 0 flipped -> IDLE.
        bus_reset();
        bad_rom = ROM ^ 64'h1;
        write_byte(8'h55, 1'b1);
        for (int i = 0; i < 8; i++) write_byte(bad_rom[8*i +: 8], 1'b1);
        write_byte(8'hBE, 1'b0);
        read_one(1'b1);
        read_one(1'b1);

        // MATCH_ROM with the correct code.
        bus_reset();
        write_byte(8'h55, 1'b1);
        for (int i = 0; i < 8; i++) write_byte(ROM[8*i +: 8], 1'b1);
        write_byte(8'hBE, 1'b1);
        read_byte(8'h50);

        // Conversion: poll reads 0 while busy, then 1.
        bus_reset();
        write_byte(8'hCC, 1'b1);
        write_byte(8'h44, 1'b1);
        check("conv_busy_started", conv_busy, 1'b1);
        read_one(1'b0);
        read_one(1'b1);
        check("conv_busy_done", conv_busy, 1'b0);

        // Full scratchpad after conversion.
        bus_reset();
        write_byte(8'hCC, 1'b1);
        write_byte(8'hBE, 1'b1);
        sp_exp = '{8'h91, 8'h01, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h00};
        sp_lo  = 64'h100CFF7F_464B0191;
`ifdef ONEWIRE_SLAVE_CRC_EN
        sp_exp[8] = ref_crc(sp_lo);
`endif
        for (int i = 0; i < 9; i++) read_byte(sp_exp[i]);

        // Reset pulse in the middle of scratchpad byte 3.
        bus_reset();
        write_byte(8'hCC, 1'b1);
        write_byte(8'hBE, 1'b1);
        for (int i = 0; i < 3; i++) read_byte(sp_exp[i]);
        read_one(1'b0);
        read_one(1'b1);
        read_one(1'b1);
        read_one(1'b0);
        bus_reset();
        write_byte(8'h33, 1'b1);
        read_byte(ROM[7:0]);

        wait_us(5);
        check("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
        check("read_queue_drained", 64'(exp_rd.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
